// File: rtl/vram_write_arbiter.sv
// Sole writer of the video RAM port A: merges touch-pen pixel writes with a
// full-screen clear sweep. All outputs except touch_ready are registered.
module vram_write_arbiter #(
  parameter int X_RES      = 480,
  parameter int Y_RES      = 272,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 9
) (
  input  logic                  cclk,
  input  logic                  rstb,
  input  logic                  touch_valid,
  output logic                  touch_ready,
  input  logic [8:0]            touch_x,
  input  logic [8:0]            touch_y,
  input  logic [DATA_WIDTH-1:0] touch_data,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  vram_wr_ena,
  output logic [ADDR_WIDTH-1:0] vram_wr_addr,
  output logic [DATA_WIDTH-1:0] vram_wr_data,
  output logic                  clear_busy,
  output logic                  clear_done
);
  localparam int PIXELS = X_RES * Y_RES;
  localparam int CW     = ADDR_WIDTH + 1;
  localparam int PW     = ADDR_WIDTH + 10;
  localparam logic [CW-1:0] SWEEP_END = CW'(PIXELS);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                state_q, state_d;
  logic                  clear_req_q, clear_req_d;
  logic                  arm_q, arm_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic                  ena_q, ena_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  clear_rise;
  logic                  on_screen;
  logic [ADDR_WIDTH-1:0] touch_addr;

  // arm_q stays low until clear_req has been seen low after reset, so a button
  // held through reset cannot look like a fresh press.
  assign clear_rise  = clear_req && !clear_req_q && arm_q;
  assign touch_ready = (state_q == IDLE) && !clear_rise;
  assign on_screen   = (PW'(touch_x) < PW'(X_RES)) && (PW'(touch_y) < PW'(Y_RES));
  // Modular arithmetic at address width equals the truncated full-width product.
  assign touch_addr  = ADDR_WIDTH'(touch_y) * ADDR_WIDTH'(X_RES) + ADDR_WIDTH'(touch_x);

  always_comb begin
    state_d     = state_q;
    clear_req_d = clear_req;
    arm_d       = arm_q || !clear_req;
    cnt_d       = cnt_q;
    color_d     = color_q;
    ena_d       = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_rise) begin
          color_d = clear_color;
          ena_d   = 1'b1;
          addr_d  = '0;
          data_d  = clear_color;
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
          state_d = CLEAR;
        end else if (touch_valid && on_screen) begin
          ena_d  = 1'b1;
          addr_d = touch_addr;
          data_d = touch_data;
        end
      end
      CLEAR: begin
        if (cnt_q == SWEEP_END) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          ena_d  = 1'b1;
          addr_d = cnt_q[ADDR_WIDTH-1:0];
          data_d = color_q;
          busy_d = 1'b1;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cclk or posedge rstb) begin
    if (rstb) begin
      state_q     <= IDLE;
      clear_req_q <= 1'b0;
      arm_q       <= 1'b0;
      cnt_q       <= '0;
      color_q     <= '0;
      ena_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_req_q <= clear_req_d;
      arm_q       <= arm_d;
      cnt_q       <= cnt_d;
      color_q     <= color_d;
      ena_q       <= ena_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign vram_wr_ena  = ena_q;
  assign vram_wr_addr = addr_q;
  assign vram_wr_data = data_q;
  assign clear_busy   = busy_q;
  assign clear_done   = done_q;
endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: full-size instance for touch addressing, a
// small-screen instance (20x5) for complete clear sweeps and reset abort.
module tb_vram_write_arbiter;
  localparam int AW   = 17;
  localparam int DW   = 9;
  localparam int SX   = 20;
  localparam int SY   = 5;
  localparam int SPIX = SX * SY;

  logic          cclk = 1'b0;
  logic          rstb = 1'b0;
  logic          touch_valid = 1'b0;
  logic [8:0]    touch_x = '0;
  logic [8:0]    touch_y = '0;
  logic [DW-1:0] touch_data = '0;
  logic          clear_req = 1'b0;
  logic [DW-1:0] clear_color = '0;

  logic          f_ready, f_ena, f_busy, f_done;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_data;
  logic          s_ready, s_ena, s_busy, s_done;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;

  always #5 cclk = ~cclk;

  vram_write_arbiter dut_full (
    .cclk(cclk), .rstb(rstb),
    .touch_valid(touch_valid), .touch_ready(f_ready),
    .touch_x(touch_x), .touch_y(touch_y), .touch_data(touch_data),
    .clear_req(clear_req), .clear_color(clear_color),
    .vram_wr_ena(f_ena), .vram_wr_addr(f_addr), .vram_wr_data(f_data),
    .clear_busy(f_busy), .clear_done(f_done)
  );

  vram_write_arbiter #(.X_RES(SX), .Y_RES(SY), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_small (
    .cclk(cclk), .rstb(rstb),
    .touch_valid(touch_valid), .touch_ready(s_ready),
    .touch_x(touch_x), .touch_y(touch_y), .touch_data(touch_data),
    .clear_req(clear_req), .clear_color(clear_color),
    .vram_wr_ena(s_ena), .vram_wr_addr(s_addr), .vram_wr_data(s_data),
    .clear_busy(s_busy), .clear_done(s_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // One cycle: drive inputs after the falling edge, settle, then the caller samples.
  task automatic drive(input logic v, input logic [8:0] x, input logic [8:0] y,
                       input logic [DW-1:0] d, input logic cr, input logic [DW-1:0] cc);
    @(negedge cclk);
    touch_valid = v;
    touch_x     = x;
    touch_y     = y;
    touch_data  = d;
    clear_req   = cr;
    clear_color = cc;
    #1;
  endtask

  typedef struct {
    logic          v;
    logic [8:0]    x;
    logic [8:0]    y;
    logic [DW-1:0] d;
    logic          rdy;
    logic          ena;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  // Starts a clear on the small instance and checks the whole sweep plus its tail.
  // The clear color input is inverted during the sweep; the latched color must win.
  // clear_req is high for loop index k < hold, and from k >= rise_again when >= 0.
  task automatic run_sweep(input string tag, input logic [DW-1:0] color, input int hold,
                           input int rise_again, input logic touch_on);
    int   bad;
    logic cr;
    bad = 0;
    drive(touch_on, 9'd1, 9'd1, 9'h0AB, 1'b1, color);
    check({tag, "_rise_ready"}, s_ready, 0);
    for (int k = 0; k < SPIX + 4; k++) begin
      cr = (k < hold) || (rise_again >= 0 && k >= rise_again);
      drive((k == SPIX + 2) ? 1'b0 : touch_on, 9'd1, 9'd1, 9'h0AB, cr, ~color);
      if (k < SPIX) begin
        if (s_ena !== 1'b1 || s_addr !== AW'(k) || s_data !== color ||
            s_busy !== 1'b1 || s_done !== 1'b0 || s_ready !== 1'b0)
          bad++;
      end else if (k == SPIX) begin
        check({tag, "_sweep_bad_cycles"}, bad, 0);
        check({tag, "_done_pulse"}, s_done, 1);
        check({tag, "_done_ena"}, s_ena, 0);
        check({tag, "_done_busy"}, s_busy, 0);
        check({tag, "_done_ready"}, s_ready, 0);
      end else if (k == SPIX + 1) begin
        check({tag, "_post_ready"}, s_ready, 1);
        check({tag, "_post_done"}, s_done, 0);
        check({tag, "_post_ena"}, s_ena, 0);
      end else if (k == SPIX + 2) begin
        check({tag, "_touch_ena"}, s_ena, touch_on);
        check({tag, "_touch_busy"}, s_busy, 0);
        if (touch_on) begin
          check({tag, "_touch_addr"}, s_addr, 1 * SX + 1);
          check({tag, "_touch_data"}, s_data, 9'h0AB);
        end
      end else begin
        check({tag, "_norestart_ena"}, s_ena, 0);
        check({tag, "_norestart_busy"}, s_busy, 0);
      end
    end
  endtask

  vec_t vecs[11];
  int   bad_rst;

  initial begin
    vecs[0]  = '{1'b1, 9'd10,  9'd2,   9'h1FF, 1'b1, 1'b0, 17'd0,      9'h000};
    vecs[1]  = '{1'b0, 9'd0,   9'd0,   9'h000, 1'b1, 1'b1, 17'd970,    9'h1FF};
    vecs[2]  = '{1'b0, 9'd0,   9'd0,   9'h000, 1'b1, 1'b0, 17'd970,    9'h1FF};
    vecs[3]  = '{1'b1, 9'd480, 9'd5,   9'h0AA, 1'b1, 1'b0, 17'd970,    9'h1FF};
    vecs[4]  = '{1'b1, 9'd3,   9'd272, 9'h055, 1'b1, 1'b0, 17'd970,    9'h1FF};
    vecs[5]  = '{1'b1, 9'd479, 9'd271, 9'h123, 1'b1, 1'b0, 17'd970,    9'h1FF};
    vecs[6]  = '{1'b0, 9'd0,   9'd0,   9'h000, 1'b1, 1'b1, 17'd130559, 9'h123};
    vecs[7]  = '{1'b1, 9'd0,   9'd0,   9'h001, 1'b1, 1'b0, 17'd130559, 9'h123};
    vecs[8]  = '{1'b1, 9'd5,   9'd100, 9'h0F0, 1'b1, 1'b1, 17'd0,      9'h001};
    vecs[9]  = '{1'b0, 9'd0,   9'd0,   9'h000, 1'b1, 1'b1, 17'd48005,  9'h0F0};
    vecs[10] = '{1'b0, 9'd0,   9'd0,   9'h000, 1'b1, 1'b0, 17'd48005,  9'h0F0};

    #1 rstb = 1'b1;
    repeat (2) @(negedge cclk);
    #1;
    check("rst_full_ena", f_ena, 0);
    check("rst_full_addr", f_addr, 0);
    check("rst_full_data", f_data, 0);
    check("rst_full_busy", f_busy, 0);
    check("rst_full_done", f_done, 0);
    check("rst_full_ready", f_ready, 1);
    check("rst_small_busy", s_busy, 0);
    rstb = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].d, 1'b0, '0);
      check($sformatf("vec%0d_ready", i), f_ready, vecs[i].rdy);
      check($sformatf("vec%0d_ena", i), f_ena, vecs[i].ena);
      check($sformatf("vec%0d_addr", i), f_addr, vecs[i].addr);
      check($sformatf("vec%0d_data", i), f_data, vecs[i].data);
    end

    // Plain clear, button held 3 cycles.
    run_sweep("clrA", 9'h000, 2, -1, 1'b0);
    // Clear with a touch in the trigger cycle, touch held throughout, and a new
    // button edge mid-sweep that stays high past DONE.
    run_sweep("clrB", 9'h1A5, 0, SPIX / 2, 1'b1);

    // Reset in the middle of a sweep.
    drive(1'b0, 9'd0, 9'd0, 9'h000, 1'b0, 9'h0F0);
    drive(1'b0, 9'd0, 9'd0, 9'h000, 1'b1, 9'h0F0);
    for (int k = 0; k <= 50; k++) drive(1'b0, 9'd0, 9'd0, 9'h000, 1'b1, 9'h0F0);
    check("rstmid_pre_addr", s_addr, 50);
    check("rstmid_pre_busy", s_busy, 1);
    #2 rstb = 1'b1;
    #1;
    check("rstmid_ena", s_ena, 0);
    check("rstmid_addr", s_addr, 0);
    check("rstmid_data", s_data, 0);
    check("rstmid_busy", s_busy, 0);
    check("rstmid_done", s_done, 0);
    repeat (2) @(negedge cclk);
    rstb = 1'b0;
    bad_rst = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 9'd0, 9'd0, 9'h000, 1'b1, 9'h0F0);
      if (s_busy !== 1'b0 || s_ena !== 1'b0 || s_done !== 1'b0 || s_ready !== 1'b1)
        bad_rst++;
    end
    check("rstmid_held_no_sweep_bad", bad_rst, 0);
    drive(1'b0, 9'd0, 9'd0, 9'h000, 1'b0, 9'h0F0);
    drive(1'b0, 9'd0, 9'd0, 9'h000, 1'b1, 9'h0F0);
    check("rstmid_retrig_ready", s_ready, 0);
    drive(1'b0, 9'd0, 9'd0, 9'h000, 1'b0, 9'h000);
    check("rstmid_retrig_ena", s_ena, 1);
    check("rstmid_retrig_addr", s_addr, 0);
    check("rstmid_retrig_data", s_data, 9'h0F0);
    check("rstmid_retrig_busy", s_busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Sole owner of the video RAM write port (port A, cclk domain).
- Arbitrates between touch-pen pixel writes and a full-screen clear sequencer.
- Converts touch (x,y) to a linear address and drops off-screen points.
- Drives the RAM's wea/addra/dina and reports clear completion to the top level.

Parameters:
X_RES, 480, visible pixels per line
Y_RES, 272, visible lines
ADDR_WIDTH, 17, RAM address width (X_RES*Y_RES = 130560 words)
DATA_WIDTH, 9, bits per pixel (3 per color)

Ports:
cclk  in  1  system clock; all logic on rising edge
rstb  in  1  reset, asynchronous, active-high (1 = in reset)
touch_valid  in  1  touch write request this cycle
touch_ready  out  1  combinational; request accepted when touch_valid && touch_ready
touch_x  in  9  touch column
touch_y  in  9  touch row
touch_data  in  DATA_WIDTH  touch pixel color
clear_req  in  1  debounced clear button, level, cclk domain
clear_color  in  DATA_WIDTH  fill color, sampled at clear start
vram_wr_ena  out  1  RAM write enable (wea)
vram_wr_addr  out  ADDR_WIDTH  RAM write address (addra)
vram_wr_data  out  DATA_WIDTH  RAM write data (dina)
clear_busy  out  1  high while the clear sweep runs
clear_done  out  1  one-cycle pulse when the sweep has written the last word

Behaviour:
- Reset: state IDLE, clear_req_d=0, sweep counter=0, color latch=0. All registered outputs 0: vram_wr_ena, vram_wr_addr, vram_wr_data, clear_busy, clear_done.
- vram_wr_* are registered. An accepted touch in cycle N produces its write in cycle N+1.
- Clear trigger: clear_rise = clear_req && !clear_req_d. clear_req_d is a register updated every cycle, including during CLEAR.
- The trigger is latched by the FSM, so releasing the button mid-sweep has no effect.
- touch_ready = (state==IDLE) && !clear_rise.
- FSM states: IDLE, CLEAR, DONE.
- IDLE:
  - If clear_rise: latch clear_color, counter<=0, go to CLEAR. Any touch that cycle is not accepted, because ready is 0.
  - Else on an accepted touch with touch_x<X_RES and touch_y<Y_RES: next cycle vram_wr_ena=1, addr = touch_y*X_RES + touch_x (full-width product truncated to ADDR_WIDTH; max 130559), data = touch_data.
  - An off-screen touch is still accepted (ready=1) but produces no write.
  - No accepted touch: vram_wr_ena=0 next cycle.
- CLEAR:
  - Each cycle: vram_wr_ena=1, addr=counter, data=latched color, counter++.
  - clear_busy=1 in all cycles where a sweep write is presented.
  - Writes occur at addresses 0..X_RES*Y_RES-1 in order, one per cycle, with no gaps. That is 130560 consecutive write cycles.
  - The first sweep write appears the cycle after clear_rise.
  - After the last address is issued, go to DONE.
  - clear_rise during CLEAR is ignored and the sweep is not restarted.
  - Touches are held off (ready=0); the source must drop or hold them.
- DONE:
  - One cycle: vram_wr_ena=0, clear_busy=0, clear_done=1. The pulse occurs the cycle after the last sweep write.
  - Return to IDLE; touch_ready rises in that IDLE cycle.
- A clear_req still held high after DONE does not retrigger; a new clear needs a new 0->1 edge.
- Between writes, vram_wr_addr and vram_wr_data hold their last value. Only vram_wr_ena is meaningful.
- Reset asserted mid-sweep: everything returns to its reset value immediately (asynchronous). The sweep is abandoned and not resumed, and no clear_done is issued.
- clear_color changes during a sweep have no effect.

Test Plan:
- Reset, then touch_valid=1 with x=10, y=2, data=0x1FF for one cycle -> next cycle wr_ena=1, addr=970, data=0x1FF; the following cycle wr_ena=0.
- Touch x=480, y=5, then x=3, y=272 -> touch_ready=1 both cycles, wr_ena stays 0. Touch x=479, y=271 -> addr=130559.
- Pulse clear_req for 3 cycles, clear_color=0x000 -> 130560 consecutive writes at addr 0..130559 with data 0 and clear_busy=1. clear_done=1 exactly one cycle after addr 130559; the next cycle touch_ready=1.
- Assert touch_valid continuously during a sweep, and toggle clear_req 0->1 mid-sweep -> touch_ready=0 throughout CLEAR and DONE, the sweep is not restarted, and the first touch write lands after DONE.
- Set clear_req=1 and touch_valid=1 in the same IDLE cycle -> touch not accepted; the next-cycle write is addr 0 with the clear color.
- Assert rstb at sweep addr 5000 -> all outputs 0 immediately, no clear_done. After release the state is IDLE, and a held-high clear_req does not start a sweep until it toggles.
